// File: rtl/stim_burst_gen.sv
// Biphasic stimulation pulse/burst generator: shadowed configuration, ramped
// DAC amplitude, optional interphase gap and ON/OFF burst scheduling.
module stim_burst_gen #(
   parameter int NELE   = 32,
   parameter int DAC_W  = 6,
   parameter int PER_W  = 12,
   parameter int PH_W   = 3,
   parameter int RAMP_W = 6,
   parameter int RF_W   = 10,
   parameter int ON_W   = 8,
   parameter int OFF_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DAC_W-1:0]  amplitude,
   input  logic [PER_W-1:0]  period,
   input  logic [PH_W-1:0]   phase_dur,
   input  logic [PH_W-1:0]   ipg,
   input  logic              biphasic,
   input  logic [RAMP_W-1:0] ramp,
   input  logic [RF_W-1:0]   ramp_factor,
   input  logic [ON_W-1:0]   on_time,
   input  logic [OFF_W-1:0]  off_time,
   input  logic [NELE-1:0]   electrode1,
   input  logic [NELE-1:0]   electrode2,
   output logic [NELE-1:0]   up_switches,
   output logic [NELE-1:0]   down_switches,
   output logic [DAC_W-1:0]  DAC,
   output logic              pulse_active,
   output logic              burst_on
);
   localparam int PW = RAMP_W + RF_W;

   typedef enum logic [2:0] {S_IDLE, S_PH1, S_IPG, S_PH2, S_WAIT, S_OFF} state_t;

   typedef struct packed {
      logic [DAC_W-1:0]  amp;
      logic [PER_W-1:0]  per;
      logic [PH_W-1:0]   pd;
      logic [PH_W-1:0]   gap;
      logic              bi;
      logic [RAMP_W-1:0] ramp_len;
      logic [RF_W-1:0]   rf;
      logic [ON_W-1:0]   on;
      logic [OFF_W-1:0]  off;
      logic [NELE-1:0]   src;
      logic [NELE-1:0]   ret;
   } cfg_t;

   state_t            state_q, state_d;
   cfg_t              cfg_q, cfg_d, cfg_in, cfg_n;
   logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d, pd_eff;
   logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
   logic [ON_W-1:0]   pulse_cnt_q, pulse_cnt_d;
   logic [OFF_W-1:0]  off_cnt_q, off_cnt_d;
   logic [RAMP_W-1:0] k_q, k_d, k_inc, kp1;
   logic              stop_q, stop_d, stop_now;
   logic              ld, ph_last, ipg_last, per_last, pulse_done, period_end;
   logic [NELE-1:0]   e1, e2, up_q, up_d, down_q, down_d;
   logic [PW-1:0]     prod, step;
   logic [DAC_W-1:0]  lvl, dac_q, dac_d;
   logic              pa_q, pa_d, bo_q, bo_d;

   always_comb begin
      cfg_in = '{amp: amplitude, per: period, pd: phase_dur, gap: ipg, bi: biphasic,
                 ramp_len: ramp, rf: ramp_factor, on: on_time, off: off_time,
                 src: electrode1, ret: electrode2};
      pd_eff   = (cfg_q.pd == '0) ? PH_W'(1) : cfg_q.pd;
      ph_last  = (ph_cnt_q == pd_eff - PH_W'(1));
      ipg_last = (ph_cnt_q == cfg_q.gap - PH_W'(1));
      // A period ends once the tick count reaches period-1; a pulse longer
      // than the period simply stretches it.
      per_last = ({1'b0, per_cnt_q} + (PER_W+1)'(1)) >= {1'b0, cfg_q.per};
      stop_now = stop_q | ~enable;
      k_inc    = (k_q < cfg_q.ramp_len) ? k_q + RAMP_W'(1) : k_q;

      state_d     = state_q;
      ph_cnt_d    = ph_cnt_q + PH_W'(1);
      per_cnt_d   = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PER_W'(1);
      pulse_cnt_d = pulse_cnt_q;
      off_cnt_d   = off_cnt_q;
      k_d         = k_q;
      stop_d      = stop_q;
      ld          = 1'b0;
      pulse_done  = 1'b0;
      period_end  = 1'b0;

      case (state_q)
         S_IDLE: begin
            ld          = 1'b1;
            stop_d      = 1'b0;
            per_cnt_d   = '0;
            pulse_cnt_d = '0;
            off_cnt_d   = '0;
            k_d         = '0;
            if (enable && cfg_in.on != '0) state_d = S_PH1;
         end
         S_PH1: begin
            stop_d = stop_now;
            if (ph_last) begin
               if (cfg_q.gap != '0) state_d = S_IPG;
               else if (cfg_q.bi)   state_d = S_PH2;
               else                 pulse_done = 1'b1;
            end
         end
         S_IPG: begin
            stop_d = stop_now;
            if (ipg_last) begin
               if (cfg_q.bi) state_d = S_PH2;
               else          pulse_done = 1'b1;
            end
         end
         S_PH2: begin
            stop_d = stop_now;
            if (ph_last) pulse_done = 1'b1;
         end
         S_WAIT: begin
            if (!enable)       state_d = S_IDLE;
            else if (per_last) period_end = 1'b1;
         end
         S_OFF: begin
            if (!enable) state_d = S_IDLE;
            else if (per_last) begin
               ld        = 1'b1;
               per_cnt_d = '0;
               if ({1'b0, off_cnt_q} + (OFF_W+1)'(1) >= {1'b0, cfg_q.off}) begin
                  state_d     = S_PH1;
                  off_cnt_d   = '0;
                  pulse_cnt_d = '0;
                  k_d         = '0;
               end else begin
                  off_cnt_d = off_cnt_q + OFF_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pulse_done) begin
         if (stop_now)      state_d = S_IDLE;
         else if (per_last) period_end = 1'b1;
         else               state_d = S_WAIT;
      end

      if (period_end) begin
         ld        = 1'b1;
         per_cnt_d = '0;
         if ({1'b0, pulse_cnt_q} + (ON_W+1)'(1) < {1'b0, cfg_q.on}) begin
            state_d     = S_PH1;
            pulse_cnt_d = pulse_cnt_q + ON_W'(1);
            k_d         = k_inc;
         end else if (cfg_q.off != '0) begin
            state_d   = S_OFF;
            off_cnt_d = '0;
         end else begin
            // Chained bursts keep the ramp position, so no re-ramp.
            state_d     = S_PH1;
            pulse_cnt_d = '0;
            k_d         = k_inc;
         end
      end

      if (state_d != state_q || ld) ph_cnt_d = '0;

      // Outputs for the coming cycle use the config that will be in the shadow.
      cfg_n = ld ? cfg_in : cfg_q;
      cfg_d = cfg_n;
      e1    = cfg_n.src & ~cfg_n.ret;
      e2    = cfg_n.ret & ~cfg_n.src;
      kp1   = k_d + RAMP_W'(1);
      prod  = PW'(kp1) * PW'(cfg_n.rf);
      step  = prod >> 4;
      lvl   = (k_d < cfg_n.ramp_len && step < PW'(cfg_n.amp)) ? step[DAC_W-1:0] : cfg_n.amp;

      up_d   = '0;
      down_d = '0;
      dac_d  = '0;
      case (state_d)
         S_PH1:   begin up_d = e1; down_d = e2; dac_d = lvl; end
         S_PH2:   begin up_d = e2; down_d = e1; dac_d = lvl; end
         default: ;
      endcase
      pa_d = (state_d == S_PH1) || (state_d == S_IPG) || (state_d == S_PH2);
      bo_d = pa_d || (state_d == S_WAIT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cfg_q       <= '0;
         ph_cnt_q    <= '0;
         per_cnt_q   <= '0;
         pulse_cnt_q <= '0;
         off_cnt_q   <= '0;
         k_q         <= '0;
         stop_q      <= 1'b0;
         up_q        <= '0;
         down_q      <= '0;
         dac_q       <= '0;
         pa_q        <= 1'b0;
         bo_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         ph_cnt_q    <= ph_cnt_d;
         per_cnt_q   <= per_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         off_cnt_q   <= off_cnt_d;
         k_q         <= k_d;
         stop_q      <= stop_d;
         up_q        <= up_d;
         down_q      <= down_d;
         dac_q       <= dac_d;
         pa_q        <= pa_d;
         bo_q        <= bo_d;
      end
   end

   assign up_switches   = up_q;
   assign down_switches = down_q;
   assign DAC           = dac_q;
   assign pulse_active  = pa_q;
   assign burst_on      = bo_q;
endmodule

// File: tb/tb_stim_burst_gen.sv
// Self-checking bench for stim_burst_gen: directed scenarios plus randomized
// configurations compared against a closed-form timing model.
module tb_stim_burst_gen;
   localparam int NELE = 32, DAC_W = 6, PER_W = 12, PH_W = 3, RAMP_W = 6;
   localparam int RF_W = 10, ON_W = 8, OFF_W = 10;
   localparam int XW = 2*NELE + DAC_W + 2;

   logic              clk = 1'b0, reset = 1'b1, enable = 1'b0;
   logic [DAC_W-1:0]  amplitude = '0;
   logic [PER_W-1:0]  period = '0;
   logic [PH_W-1:0]   phase_dur = '0, ipg = '0;
   logic              biphasic = 1'b0;
   logic [RAMP_W-1:0] ramp = '0;
   logic [RF_W-1:0]   ramp_factor = '0;
   logic [ON_W-1:0]   on_time = '0;
   logic [OFF_W-1:0]  off_time = '0;
   logic [NELE-1:0]   electrode1 = '0, electrode2 = '0;
   logic [NELE-1:0]   up_switches, down_switches;
   logic [DAC_W-1:0]  DAC;
   logic              pulse_active, burst_on;

   int errs = 0, checks = 0;
   wire [XW-1:0] act = {up_switches, down_switches, DAC, pulse_active, burst_on};

   stim_burst_gen dut (
      .clk(clk), .reset(reset), .enable(enable), .amplitude(amplitude), .period(period),
      .phase_dur(phase_dur), .ipg(ipg), .biphasic(biphasic), .ramp(ramp),
      .ramp_factor(ramp_factor), .on_time(on_time), .off_time(off_time),
      .electrode1(electrode1), .electrode2(electrode2), .up_switches(up_switches),
      .down_switches(down_switches), .DAC(DAC), .pulse_active(pulse_active),
      .burst_on(burst_on));

   always #5 clk = ~clk;

   // Expected outputs t cycles after the enabling edge, for a static config.
   // Pulse starts repeat every max(period, pulse length); OFF periods last
   // max(period,1); the ramp index is the pulse number within the ON burst.
   function automatic logic [XW-1:0] model(input int t);
      int pd, len, pe, po, cyc, r, k, o, stp, dv, ph;
      logic inb;
      logic [NELE-1:0] a, b, up, dn;
      if (on_time == 0) return '0;
      pd  = (phase_dur == 0) ? 1 : int'(phase_dur);
      len = pd + int'(ipg) + (biphasic ? pd : 0);
      pe  = (int'(period) > len) ? int'(period) : len;
      po  = (period == 0) ? 1 : int'(period);
      inb = 1'b1;
      k   = t / pe;
      o   = t % pe;
      if (off_time != 0) begin
         cyc = int'(on_time) * pe + int'(off_time) * po;
         r   = t % cyc;
         inb = (r < int'(on_time) * pe);
         k   = r / pe;
         o   = r % pe;
      end
      if (!inb)                             ph = 0;
      else if (o < pd)                      ph = 1;
      else if (o < pd + int'(ipg))          ph = 2;
      else if (biphasic && o < len)         ph = 3;
      else                                  ph = 0;
      stp = ((k + 1) * int'(ramp_factor)) / 16;
      dv  = (k < int'(ramp) && stp < int'(amplitude)) ? stp : int'(amplitude);
      a   = electrode1 & ~electrode2;
      b   = electrode2 & ~electrode1;
      up  = (ph == 1) ? a : (ph == 3) ? b : '0;
      dn  = (ph == 1) ? b : (ph == 3) ? a : '0;
      if (ph != 1 && ph != 3) dv = 0;
      return {up, dn, DAC_W'(dv), ph != 0, inb};
   endfunction

   task automatic quiesce();
      reset  = 1'b0;
      enable = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   task automatic start();
      repeat (2) @(negedge clk);
      enable = 1'b1;
   endtask

   task automatic set_cfg(input int amp, per, pd, gp, bi, rmp, rf, on, off,
                          input logic [NELE-1:0] s, d);
      amplitude = DAC_W'(amp); period = PER_W'(per); phase_dur = PH_W'(pd);
      ipg = PH_W'(gp); biphasic = bi[0]; ramp = RAMP_W'(rmp); ramp_factor = RF_W'(rf);
      on_time = ON_W'(on); off_time = OFF_W'(off); electrode1 = s; electrode2 = d;
   endtask

   task automatic test_reset();
      logic [XW-1:0] exp;
      reset = 1'b1; enable = 1'b0;
      set_cfg(7, 20, 4, 0, 1, 0, 16, 3, 0, 32'h8, 32'h20);
      repeat (3) @(negedge clk);
      checks++;
      if (act !== '0) begin errs++; $display("FAIL reset_state got=%h exp=0", act); end
      reset = 1'b0; enable = 1'b1;
      @(negedge clk);
      exp = model(0); checks++;
      if (act !== exp) begin errs++; $display("FAIL first_ph1 got=%h exp=%h", act, exp); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (act !== '0) begin errs++; $display("FAIL async_clear got=%h exp=0", act); end
      @(negedge clk);
      checks++;
      if (act !== '0) begin errs++; $display("FAIL held_reset got=%h exp=0", act); end
      reset = 1'b0;
      for (int t = 0; t < 25; t++) begin
         @(negedge clk);
         exp = model(t); checks++;
         if (act !== exp) begin errs++; $display("FAIL restart t=%0d got=%h exp=%h", t, act, exp); end
      end
   endtask

   task automatic test_nominal();
      logic [XW-1:0] exp;
      quiesce();
      set_cfg(50, 400, 4, 1, 1, 50, 16, 50, 50, 32'h8000, 32'h4000);
      start();
      for (int t = 0; t < 40500; t++) begin
         @(negedge clk);
         exp = model(t); checks++;
         if (act !== exp) begin errs++; $display("FAIL nominal t=%0d got=%h exp=%h", t, act, exp); end
         if (t == 0 || t == 400 || t == 49*400 || t == 40000) begin
            checks++;
            if (DAC !== ((t == 49*400) ? 6'd50 : (t == 400) ? 6'd2 : 6'd1) || up_switches !== 32'h8000
                || down_switches !== 32'h4000)
               begin errs++; $display("FAIL nominal_ph1 t=%0d got dac=%0d up=%h dn=%h", t, DAC, up_switches, down_switches); end
         end
         if (t == 4 || t == 5) begin
            checks++;
            if (up_switches !== ((t == 5) ? 32'h4000 : 32'h0) || down_switches !== ((t == 5) ? 32'h8000 : 32'h0)
                || pulse_active !== 1'b1)
               begin errs++; $display("FAIL nominal_gap_ph2 t=%0d got up=%h dn=%h pa=%b", t, up_switches, down_switches, pulse_active); end
         end
         if (t == 20000 || t == 39999) begin
            checks++;
            if (burst_on !== 1'b0 || pulse_active !== 1'b0)
               begin errs++; $display("FAIL nominal_off t=%0d got bo=%b pa=%b exp 0", t, burst_on, pulse_active); end
         end
      end
   endtask

   task automatic test_saturation();
      logic [XW-1:0] exp;
      logic [DAC_W-1:0] want [5] = '{6'd1, 6'd2, 6'd3, 6'd5, 6'd25};
      int idx [5] = '{0, 1, 2, 3, 19};
      quiesce();
      set_cfg(25, 12, 2, 0, 1, 25, 20, 30, 1, 32'h1, 32'h2);
      start();
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         exp = model(t); checks++;
         if (act !== exp) begin errs++; $display("FAIL saturation t=%0d got=%h exp=%h", t, act, exp); end
         for (int i = 0; i < 5; i++)
            if (t == idx[i] * 12) begin
               checks++;
               if (DAC !== want[i]) begin errs++; $display("FAIL sat_dac pulse=%0d got=%0d exp=%0d", idx[i], DAC, want[i]); end
            end
      end
   endtask

   task automatic test_disable();
      logic [XW-1:0] exp;
      logic [NELE-1:0] u, d;
      logic [DAC_W-1:0] a;
      int o;
      quiesce();
      set_cfg(10, 20, 3, 1, 1, 0, 16, 5, 0, 32'h1, 32'h2);
      start();
      for (int t = 0; t < 36; t++) begin
         @(negedge clk);
         o = t % 20;
         a = (t < 20) ? 6'd10 : 6'd20;
         u = '0; d = '0;
         if (o < 3)                 begin u = 32'h1; d = 32'h2; end
         else if (o >= 4 && o < 7)  begin u = 32'h2; d = 32'h1; end
         exp = {u, d, (u != 0) ? a : 6'd0, o < 7, 1'b1};
         if (t >= 27) exp = '0;
         checks++;
         if (act !== exp) begin errs++; $display("FAIL disable t=%0d got=%h exp=%h", t, act, exp); end
         if (t == 0)  amplitude = 6'd20;
         if (t == 20) enable = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [XW-1:0] exp;
      quiesce();
      set_cfg(30, 5, 4, 2, 1, 0, 0, 3, 0, 32'h10, 32'h100);
      start();
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         exp = model(t); checks++;
         if (act !== exp) begin errs++; $display("FAIL b2b t=%0d got=%h exp=%h", t, act, exp); end
         if (t == 9 || t == 10 || t == 20) begin
            checks++;
            if (pulse_active !== 1'b1 || up_switches !== ((t == 9) ? 32'h100 : 32'h10))
               begin errs++; $display("FAIL b2b_edge t=%0d got pa=%b up=%h", t, pulse_active, up_switches); end
         end
      end
   endtask

   task automatic test_corners();
      logic [XW-1:0] exp;
      quiesce();
      set_cfg(9, 10, 3, 1, 0, 0, 0, 4, 0, 32'h4, 32'h8);
      start();
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         exp = model(t); checks++;
         if (act !== exp) begin errs++; $display("FAIL mono t=%0d got=%h exp=%h", t, act, exp); end
         if (t % 10 == 4) begin
            checks++;
            if (pulse_active !== 1'b0 || up_switches !== '0)
               begin errs++; $display("FAIL mono_no_ph2 t=%0d got pa=%b up=%h", t, pulse_active, up_switches); end
         end
      end
      quiesce();
      set_cfg(9, 10, 2, 0, 1, 0, 0, 4, 0, 32'h1, 32'h1);
      start();
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         checks++;
         if (up_switches !== '0 || down_switches !== '0 || pulse_active !== (t % 10 < 4))
            begin errs++; $display("FAIL overlap t=%0d got up=%h dn=%h pa=%b", t, up_switches, down_switches, pulse_active); end
      end
      quiesce();
      set_cfg(9, 10, 2, 0, 1, 0, 0, 0, 0, 32'h1, 32'h2);
      start();
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         checks++;
         if (act !== '0) begin errs++; $display("FAIL on_zero t=%0d got=%h exp=0", t, act); end
      end
   endtask

   task automatic test_random();
      logic [XW-1:0] exp;
      for (int n = 0; n < 12; n++) begin
         quiesce();
         set_cfg($urandom_range(1, 63), $urandom_range(0, 30), $urandom_range(0, 7),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 8),
                 $urandom_range(0, 1023), $urandom_range(1, 4), $urandom_range(0, 3),
                 NELE'($urandom & 32'hFF), NELE'($urandom & 32'hFF));
         start();
         for (int t = 0; t < 250; t++) begin
            @(negedge clk);
            exp = model(t); checks++;
            if (act !== exp || (up_switches & down_switches) !== '0)
               begin errs++; $display("FAIL random n=%0d t=%0d got=%h exp=%h", n, t, act, exp); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_disable();
      test_back_to_back();
      test_corners();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
